apb_csr_multi: RTL

//  APB3 register slave for NUM_CH serial-controller channels (I2C-style). Per channel:

---
 rtl/apb_csr_multi.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/apb_csr_multi.sv
// apb_csr_multi: APB3 CSR slave for NUM_CH serial channels with FIFO wait states and PSLVERR; define APB_CSR_IRQ_EN for IRQEN/irq
module apb_csr_multi #(
  parameter int ADDRESSWIDTH = 6,
  parameter int DATAWIDTH = 8,
  parameter int NUM_CH = 2,
  parameter int WAIT_MAX = 15
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [ADDRESSWIDTH-1:0]       PADDR,
  input  logic [DATAWIDTH-1:0]          PWDATA,
  input  logic                          PWRITE,
  input  logic                          PSELx,
  input  logic                          PENABLE,
  output logic [DATAWIDTH-1:0]          PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  input  logic [NUM_CH-1:0]             tx_full,
  input  logic [NUM_CH-1:0]             rx_empty,
  input  logic [NUM_CH*8-1:0]           status_in,
  input  logic [NUM_CH*DATAWIDTH-1:0]   rx_data,
  output logic [NUM_CH-1:0]             tx_push,
  output logic [DATAWIDTH-1:0]          tx_data,
  output logic [NUM_CH-1:0]             rx_pop,
  output logic [NUM_CH*8-1:0]           cmd,
  output logic [NUM_CH*7-1:0]           slv_addr
`ifdef APB_CSR_IRQ_EN
  ,
  output logic                          irq
`endif
);
  localparam int DW = DATAWIDTH;
  localparam int CHW = ADDRESSWIDTH - 3;
  localparam int CW = WAIT_MAX > 0 ? $clog2(WAIT_MAX + 1) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] prdata_q, prdata_d, tx_data_q, tx_data_d, rd, sel_rx;
  logic pready_q, pready_d, pslverr_q, pslverr_d;
  logic [NUM_CH-1:0] tx_push_q, tx_push_d, rx_pop_q, rx_pop_d;
  logic [NUM_CH*8-1:0] cmd_q, cmd_d;
  logic [NUM_CH*7-1:0] slv_addr_q, slv_addr_d;
  logic [CHW-1:0] ch;
  logic [2:0] off;
  logic [7:0] sel_cmd, sel_status;
  logic [6:0] sel_saddr;
  logic sel_full, sel_empty, off_ok, bad, stall, to_done, err, ok;
  logic unused_ok;
`ifdef APB_CSR_IRQ_EN
  logic [NUM_CH*3-1:0] irqen_q, irqen_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic [2:0] sel_irqen;
  logic irq_q, irq_d;
`endif
  // Decode the addressed register, decide wait/done/error and compute next register state
  always_comb begin
    ch = PADDR[ADDRESSWIDTH-1:3];
    off = PADDR[2:0];
    unused_ok = ^status_in;
    sel_cmd = '0;
    sel_status = '0;
    sel_saddr = '0;
    sel_rx = '0;
    sel_full = 1'b0;
    sel_empty = 1'b0;
`ifdef APB_CSR_IRQ_EN
    sel_irqen = '0;
    off_ok = off <= 3'd5;
`else
    off_ok = off <= 3'd4;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == CHW'(i)) begin
        sel_cmd = cmd_q[i*8 +: 8];
        sel_status = status_in[i*8 +: 8];
        sel_saddr = slv_addr_q[i*7 +: 7];
        sel_rx = rx_data[i*DW +: DW];
        sel_full = tx_full[i];
        sel_empty = rx_empty[i];
`ifdef APB_CSR_IRQ_EN
        sel_irqen = irqen_q[i*3 +: 3];
`endif
      end
    end
    bad = !(int'(ch) < NUM_CH) || !off_ok || (PWRITE && (off == 3'd2 || off == 3'd3)) || (!PWRITE && off == 3'd1);
    stall = !bad && ((PWRITE && off == 3'd1 && sel_full) || (!PWRITE && off == 3'd3 && sel_empty));
    to_done = state_q == ACCESS && PSELx && !(stall && cnt_q != CW'(WAIT_MAX));
    err = bad || stall;
    ok = to_done && !err;
    state_d = state_q == IDLE ? (PSELx && PENABLE ? ACCESS : IDLE) :
              state_q == DONE ? IDLE : !PSELx ? IDLE : to_done ? DONE : ACCESS;
    cnt_d = state_q == ACCESS && PSELx && stall && !to_done ? cnt_q + CW'(1) : '0;
    rd = off == 3'd0 ? DW'(sel_cmd) :
         off == 3'd2 ? DW'({sel_full, 2'b00, sel_empty, sel_status[3:0]}) :
         off == 3'd3 ? sel_rx :
         off == 3'd4 ? DW'(sel_saddr) :
`ifdef APB_CSR_IRQ_EN
         DW'(sel_irqen);
`else
         '0;
`endif
    pready_d = to_done;
    pslverr_d = to_done && err;
    prdata_d = ok && !PWRITE ? rd : '0;
    tx_data_d = ok && PWRITE && off == 3'd1 ? PWDATA : tx_data_q;
    slv_addr_d = slv_addr_q;
    tx_push_d = '0;
    rx_pop_d = '0;
`ifdef APB_CSR_IRQ_EN
    irqen_d = irqen_q;
    err_d = err_q;
    irq_d = 1'b0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      cmd_d[i*8 +: 8] = {4'b0000, cmd_q[i*8 +: 4]};
      if (ok && ch == CHW'(i)) begin
        if (PWRITE && off == 3'd0) cmd_d[i*8 +: 8] = PWDATA[7:0];
        if (PWRITE && off == 3'd4) slv_addr_d[i*7 +: 7] = PWDATA[6:0];
        tx_push_d[i] = PWRITE && off == 3'd1;
        rx_pop_d[i] = !PWRITE && off == 3'd3;
`ifdef APB_CSR_IRQ_EN
        if (PWRITE && off == 3'd5) begin
          irqen_d[i*3 +: 3] = PWDATA[2:0];
          err_d[i] = err_q[i] && PWDATA[2];
        end
`endif
      end
`ifdef APB_CSR_IRQ_EN
      if (to_done && err && ch == CHW'(i)) err_d[i] = 1'b1;
      irq_d = irq_d | (irqen_q[i*3] && !rx_empty[i]) | (irqen_q[i*3+1] && !tx_full[i]) | (irqen_q[i*3+2] && err_q[i]);
`endif
    end
  end
  // State, wait counter and all registered outputs
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
      prdata_q <= '0;
      pready_q <= 1'b0;
      pslverr_q <= 1'b0;
      tx_push_q <= '0;
      rx_pop_q <= '0;
      tx_data_q <= '0;
      cmd_q <= '0;
      slv_addr_q <= '0;
`ifdef APB_CSR_IRQ_EN
      irqen_q <= '0;
      err_q <= '0;
      irq_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      prdata_q <= prdata_d;
      pready_q <= pready_d;
      pslverr_q <= pslverr_d;
      tx_push_q <= tx_push_d;
      rx_pop_q <= rx_pop_d;
      tx_data_q <= tx_data_d;
      cmd_q <= cmd_d;
      slv_addr_q <= slv_addr_d;
`ifdef APB_CSR_IRQ_EN
      irqen_q <= irqen_d;
      err_q <= err_d;
      irq_q <= irq_d;
`endif
    end
  end
  assign PRDATA = prdata_q;
  assign PREADY = pready_q;
  assign PSLVERR = pslverr_q;
  assign tx_push = tx_push_q;
  assign rx_pop = rx_pop_q;
  assign tx_data = tx_data_q;
  assign cmd = cmd_q;
  assign slv_addr = slv_addr_q;
`ifdef APB_CSR_IRQ_EN
  assign irq = irq_q;
`endif
endmodule
